// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encodings and a
// constant-evaluable max helper used to size the phase counter.
// No logic, no latency, no flow control.
package pulse_stretch_pkg;

    // Encodings are fixed so that waveforms and any external decode agree.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Usable in parameter/localparam expressions (elaboration-time only).
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretch_sat_counter.sv
// Up/down counter that saturates at 0 and MAX and flags an increment refused at MAX.
// Latency: count updates on the clock edge after i_inc/i_dec; o_ovf_attempt is combinational.
// Backpressure: none; a refused increment is reported, never stalled.
//
// Ports
//   clock          in   1        rising-edge clock
//   i_nrst         in   1        asynchronous active-low reset, clears the count
//   i_inc          in   1        request +1
//   i_dec          in   1        request -1 (inc and dec together cancel out)
//   o_count        out  W        registered count, 0..MAX
//   o_ovf_attempt  out  1        inc alone requested while already at MAX
module sat_counter #(
    parameter int MAX = 4
) (
    input  logic                       clock,
    input  logic                       i_nrst,
    input  logic                       i_inc,
    input  logic                       i_dec,
    output logic [$clog2(MAX+1)-1:0]   o_count,
    output logic                       o_ovf_attempt
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d       = count_q;
        o_ovf_attempt = 1'b0;
        case ({i_inc, i_dec})
            2'b10: begin
                if (count_q == MAX_V) begin
                    o_ovf_attempt = 1'b1;
                end else begin
                    count_d = count_q + W'(1);
                end
            end
            2'b01: begin
                if (count_q != '0) begin
                    count_d = count_q - W'(1);
                end
            end
            // Both or neither: net-zero change, so a simultaneous pair can
            // never be the cause of an overflow.
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pulse_stretch.sv
// Stretches one-cycle event strobes into pulses with guaranteed high time and low gap.
// Latency: event sampled at edge N drives o_out high from N+1 for HIGH_CYCLES, then low for LOW_CYCLES.
// Backpressure: none upstream; events during a pulse queue up to MAX_PENDING, extra ones set o_overflow.
//
// Ports
//   clock       in   1        rising-edge clock
//   i_nrst      in   1        asynchronous active-low reset; aborts any pulse and drops the queue
//   i_event     in   1        one-cycle event strobe
//   i_clr_ovf   in   1        clears the sticky overflow flag (a same-cycle drop wins)
//   o_out       out  1        stretched pulse, registered
//   o_busy      out  1        registered, high whenever the FSM is not idle
//   o_pending   out  PW       registered count of queued events
//   o_overflow  out  1        registered sticky flag, an event was dropped
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HIGH_CYCLES = 16,
    parameter int LOW_CYCLES  = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                               clock,
    input  logic                               i_nrst,
    input  logic                               i_event,
    input  logic                               i_clr_ovf,
    output logic                               o_out,
    output logic                               o_busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   o_pending,
    output logic                               o_overflow
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    // Phase counter only ever reaches max(HIGH,LOW)-1, but is sized for the
    // full max so single-cycle phases still get a legal one-bit counter.
    localparam int CW = $clog2(max2(HIGH_CYCLES, LOW_CYCLES) + 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);

    state_e         state_q;
    state_e         state_d;
    logic [CW-1:0]  phase_q;
    logic [CW-1:0]  phase_d;
    logic           out_q;
    logic           out_d;
    logic           busy_q;
    logic           busy_d;
    logic           overflow_q;
    logic           overflow_d;

    logic           last_high;
    logic           last_low;
    logic           pend_inc;
    logic           pend_dec;
    logic           pend_ovf;
    logic [PW-1:0]  pend_cnt;

    assign last_high = (state_q == ST_HIGH) && (phase_q == HIGH_LAST);
    assign last_low  = (state_q == ST_LOW)  && (phase_q == LOW_LAST);

    // ------------------------------------------------------------------
    // Pending queue control
    // ------------------------------------------------------------------
    // An event in IDLE is consumed directly by the IDLE->HIGH transition.
    // Anywhere else it is queued. On the final LOW cycle the queue is also
    // popped; a same-cycle event then cancels the pop inside sat_counter,
    // which is exactly "effective pending - 1" with no overflow possible.
    // Popping an empty queue saturates at zero, i.e. no change.
    assign pend_inc = i_event && (state_q != ST_IDLE);
    assign pend_dec = last_low;

    sat_counter #(
        .MAX (MAX_PENDING)
    ) u_pending (
        .clock         (clock),
        .i_nrst        (i_nrst),
        .i_inc         (pend_inc),
        .i_dec         (pend_dec),
        .o_count       (pend_cnt),
        .o_ovf_attempt (pend_ovf)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    assign overflow_d = pend_ovf | (overflow_q & ~i_clr_ovf);

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_event) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (last_high) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (last_low) begin
                    // Go straight back to HIGH (no idle cycle) if anything is
                    // queued or an event lands on this very cycle.
                    state_d = (i_event || (pend_cnt != '0)) ? ST_HIGH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase counter restarts at 0 on every state change, including LOW->HIGH.
    always_comb begin
        phase_d = '0;
        if ((state_q != ST_IDLE) && (state_d == state_q)) begin
            phase_d = phase_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (decoded from the next state, then registered so
    // that the outputs line up with the state they describe)
    // ------------------------------------------------------------------
    always_comb begin
        out_d  = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // FSM: state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_out      = out_q;
    assign o_busy     = busy_q;
    assign o_pending  = pend_cnt;
    assign o_overflow = overflow_q;

endmodule
